// File: rtl/seq_detect_sched_pkg.sv
// Shared types, widths and helpers for the run-length sequence detector.
package seq_detect_pkg;

  localparam int NCH_DEF   = 4;
  localparam int CNT_W_DEF = 4;
  localparam int CH_W_DEF  = $clog2(NCH_DEF);
  localparam int DET_CNT_W = 16;

  // A programmed length of zero is treated as a run of one.
  function automatic logic [31:0] eff_len(input logic [31:0] len);
    return (len == 32'd0) ? 32'd1 : len;
  endfunction

endpackage

// File: rtl/seq_detect_sched_if.sv
// Channel/event bundle between the detector and its environment.
interface seq_detect_sched_if
  import seq_detect_pkg::*;
#(
  parameter int NCH   = NCH_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int CH_W  = $clog2(NCH)
);

  logic [CNT_W-1:0]     cfg_len;
  logic [NCH-1:0]       in_valid;
  logic [NCH-1:0]       in_bit;
  logic [NCH-1:0]       in_ready;
  logic [NCH-1:0]       det;
  logic                 ev_valid;
  logic [CH_W-1:0]      ev_ch;
  logic                 ev_ready;
  logic [DET_CNT_W-1:0] det_cnt;

  modport master (
    output cfg_len, in_valid, in_bit, ev_ready,
    input  in_ready, det, ev_valid, ev_ch, det_cnt
  );

  modport slave (
    input  cfg_len, in_valid, in_bit, ev_ready,
    output in_ready, det, ev_valid, ev_ch, det_cnt
  );

endinterface

// File: rtl/seq_detect_sched_rr_arb.sv
// Round-robin arbiter: first requester at or after ptr, wrapping; one-hot grant.
module rr_arb #(
  parameter int NCH  = 4,
  parameter int CH_W = $clog2(NCH)
) (
  input  logic [NCH-1:0]  req,
  input  logic            en,
  input  logic [CH_W-1:0] ptr,
  output logic [NCH-1:0]  gnt,
  output logic [CH_W-1:0] gnt_id
);

  int   w_idx;
  logic w_found;

  // Scan from ptr around the ring and grant the first active request.
  always_comb begin
    gnt     = '0;
    gnt_id  = '0;
    w_found = 1'b0;
    w_idx   = 0;
    for (int k = 0; k < NCH; k++) begin
      w_idx = (int'(ptr) + k) % NCH;
      if (en && !w_found && req[w_idx]) begin
        gnt[w_idx] = 1'b1;
        gnt_id     = CH_W'(w_idx);
        w_found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seq_detect_sched.sv
// Time-shared run-length detector: one granted channel per cycle updates its
// run counter; the completing accept of a run posts a one-entry event.
module seq_detect_sched
  import seq_detect_pkg::*;
#(
  parameter int NCH   = NCH_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int CH_W  = $clog2(NCH)
) (
  input logic              clk,
  input logic              rst,
  seq_detect_sched_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0]     r_run [NCH];
  logic [CH_W-1:0]      r_ptr;
  logic                 r_ev_valid;
  logic [CH_W-1:0]      r_ev_ch;
  logic [DET_CNT_W-1:0] r_det_cnt;

  logic                 w_slot_free;
  logic                 w_arb_en;
  logic [NCH-1:0]       w_gnt;
  logic [CH_W-1:0]      w_gnt_id;
  logic                 w_accept;
  logic                 w_bit;
  logic [CNT_W-1:0]     w_run_g;
  logic [CNT_W-1:0]     w_run_inc;
  logic [CNT_W-1:0]     w_eff_len;
  logic                 w_event;
  logic [CH_W-1:0]      w_ptr_nxt;

  // No grants while the event slot is occupied and not draining, or in reset.
  assign w_slot_free = !r_ev_valid || bus.ev_ready;
  assign w_arb_en    = w_slot_free && !rst;

  rr_arb #(.NCH(NCH), .CH_W(CH_W)) u_arb (
    .req    (bus.in_valid),
    .en     (w_arb_en),
    .ptr    (r_ptr),
    .gnt    (w_gnt),
    .gnt_id (w_gnt_id)
  );

  assign bus.in_ready = w_gnt;
  assign w_accept     = |w_gnt;
  assign w_bit        = bus.in_bit[w_gnt_id];
  assign w_run_g      = r_run[w_gnt_id];
  assign w_run_inc    = (w_run_g == CNT_MAX) ? w_run_g : w_run_g + 1'b1;
  assign w_eff_len    = CNT_W'(eff_len(32'(bus.cfg_len)));

  // Compare with one extra bit so a saturated run never aliases eff_len.
  assign w_event = w_accept && w_bit &&
                   (({1'b0, w_run_g} + 1'b1) == {1'b0, w_eff_len});

  assign w_ptr_nxt = (w_gnt_id == CH_W'(NCH - 1)) ? '0 : w_gnt_id + 1'b1;

  // Per-channel run counters; only the granted channel moves.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) r_run[i] <= '0;
    end else if (w_accept) begin
      r_run[w_gnt_id] <= w_bit ? w_run_inc : '0;
    end
  end

  // Round-robin pointer advances past each granted channel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_ptr <= '0;
    else if (w_accept) r_ptr <= w_ptr_nxt;
  end

  // Event slot and running event count; a new event wins over a pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ev_valid <= 1'b0;
      r_ev_ch    <= '0;
      r_det_cnt  <= '0;
    end else if (w_event) begin
      r_ev_valid <= 1'b1;
      r_ev_ch    <= w_gnt_id;
      r_det_cnt  <= r_det_cnt + 1'b1;
    end else if (bus.ev_ready) begin
      r_ev_valid <= 1'b0;
    end
  end

  // Detection level follows the live run count against the live length.
  always_comb begin
    bus.det = '0;
    for (int i = 0; i < NCH; i++) bus.det[i] = (r_run[i] >= w_eff_len);
  end

  assign bus.ev_valid = r_ev_valid;
  assign bus.ev_ch    = r_ev_ch;
  assign bus.det_cnt  = r_det_cnt;

endmodule

// File: tb/tb_seq_detect_sched.sv
// Directed bench for seq_detect_sched with hand-computed expectations.
module tb_seq_detect_sched;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  seq_detect_sched_if #(.NCH(4), .CNT_W(4)) bus ();

  seq_detect_sched #(.NCH(4), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    bus.in_valid = '0;
    bus.in_bit   = '0;
    bus.ev_ready = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    bus.cfg_len  = 4'd3;
    bus.ev_ready = 1'b1;
    bus.in_valid = 4'b1111;
    bus.in_bit   = 4'b1111;
    rst          = 1'b1;
    tick();
    checks++; if (bus.in_ready !== 4'b0000) begin failures++; $display("FAIL reset_in_ready got=%b exp=0000", bus.in_ready); end
    checks++; if (bus.det !== 4'b0000) begin failures++; $display("FAIL reset_det got=%b exp=0000", bus.det); end
    checks++; if (bus.ev_valid !== 1'b0) begin failures++; $display("FAIL reset_ev_valid got=%b exp=0", bus.ev_valid); end
    checks++; if (bus.ev_ch !== 2'd0) begin failures++; $display("FAIL reset_ev_ch got=%0d exp=0", bus.ev_ch); end
    checks++; if (bus.det_cnt !== 16'd0) begin failures++; $display("FAIL reset_det_cnt got=%0d exp=0", bus.det_cnt); end
    do_reset();
  endtask

  task automatic test_single();
    logic [4:0] bits, e_det, e_ev;
    bits  = 5'b01111;
    e_det = 5'b01100;
    e_ev  = 5'b00100;
    do_reset();
    bus.cfg_len = 4'd3;
    for (int k = 0; k < 5; k++) begin
      bus.in_valid = 4'b0001;
      bus.in_bit   = {3'b000, bits[k]};
      #1;
      checks++; if (bus.in_ready !== 4'b0001) begin failures++; $display("FAIL single_in_ready step=%0d got=%b exp=0001", k, bus.in_ready); end
      tick();
      checks++; if (bus.det[0] !== e_det[k]) begin failures++; $display("FAIL single_det step=%0d got=%b exp=%b", k, bus.det[0], e_det[k]); end
      checks++; if (bus.ev_valid !== e_ev[k]) begin failures++; $display("FAIL single_ev_valid step=%0d got=%b exp=%b", k, bus.ev_valid, e_ev[k]); end
      if (k == 2) begin
        checks++; if (bus.ev_ch !== 2'd0) begin failures++; $display("FAIL single_ev_ch got=%0d exp=0", bus.ev_ch); end
      end
    end
    checks++; if (bus.det_cnt !== 16'd1) begin failures++; $display("FAIL single_det_cnt got=%0d exp=1", bus.det_cnt); end
    bus.in_valid = '0;
  endtask

  task automatic test_round_robin();
    int cnt [4];
    logic [3:0] exp_g;
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    do_reset();
    bus.cfg_len  = 4'd3;
    bus.in_valid = 4'b1111;
    bus.in_bit   = 4'b0000;
    for (int c = 0; c < 16; c++) begin
      #1;
      exp_g = 4'b0001 << (c % 4);
      checks++; if (bus.in_ready !== exp_g) begin failures++; $display("FAIL rr_grant cyc=%0d got=%b exp=%b", c, bus.in_ready, exp_g); end
      for (int i = 0; i < 4; i++) if (bus.in_ready[i] === 1'b1) cnt[i]++;
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      checks++; if (cnt[i] !== 4) begin failures++; $display("FAIL rr_count ch=%0d got=%0d exp=4", i, cnt[i]); end
    end
    bus.in_valid = '0;
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.cfg_len  = 4'd2;
    bus.ev_ready = 1'b0;
    bus.in_valid = 4'b0001;
    bus.in_bit   = 4'b0001;
    tick();
    tick();
    checks++; if (bus.ev_valid !== 1'b1) begin failures++; $display("FAIL bp_ev_valid got=%b exp=1", bus.ev_valid); end
    bus.in_valid = 4'b1111;
    bus.in_bit   = 4'b0000;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (bus.in_ready !== 4'b0000) begin failures++; $display("FAIL bp_stall cyc=%0d got=%b exp=0000", c, bus.in_ready); end
      tick();
      checks++; if (bus.det[0] !== 1'b1) begin failures++; $display("FAIL bp_frozen cyc=%0d got=%b exp=1", c, bus.det[0]); end
      checks++; if ({bus.ev_valid, bus.ev_ch} !== 3'b100) begin failures++; $display("FAIL bp_hold cyc=%0d got=%b exp=100", c, {bus.ev_valid, bus.ev_ch}); end
    end
    checks++; if (bus.det_cnt !== 16'd1) begin failures++; $display("FAIL bp_det_cnt got=%0d exp=1", bus.det_cnt); end
    bus.ev_ready = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 4'b0010) begin failures++; $display("FAIL bp_resume got=%b exp=0010", bus.in_ready); end
    tick();
    checks++; if (bus.ev_valid !== 1'b0) begin failures++; $display("FAIL bp_pop got=%b exp=0", bus.ev_valid); end
    checks++; if (bus.det[0] !== 1'b1) begin failures++; $display("FAIL bp_hold_ch0 got=%b exp=1", bus.det[0]); end
    bus.in_valid = '0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    bus.cfg_len  = 4'd2;
    bus.ev_ready = 1'b1;
    bus.in_valid = 4'b0011;
    bus.in_bit   = 4'b0011;
    tick();
    tick();
    checks++; if (bus.ev_valid !== 1'b0) begin failures++; $display("FAIL b2b_early got=%b exp=0", bus.ev_valid); end
    tick();
    checks++; if ({bus.ev_valid, bus.ev_ch} !== 3'b100) begin failures++; $display("FAIL b2b_first got=%b exp=100", {bus.ev_valid, bus.ev_ch}); end
    bus.in_valid = 4'b0010;
    tick();
    checks++; if ({bus.ev_valid, bus.ev_ch} !== 3'b101) begin failures++; $display("FAIL b2b_second got=%b exp=101", {bus.ev_valid, bus.ev_ch}); end
    checks++; if (bus.det_cnt !== 16'd2) begin failures++; $display("FAIL b2b_det_cnt got=%0d exp=2", bus.det_cnt); end
    bus.in_valid = '0;
    tick();
    checks++; if (bus.ev_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain got=%b exp=0", bus.ev_valid); end
  endtask

  task automatic test_len_zero();
    do_reset();
    bus.cfg_len  = 4'd0;
    bus.in_valid = 4'b0100;
    bus.in_bit   = 4'b0100;
    tick();
    checks++; if ({bus.ev_valid, bus.ev_ch} !== 3'b110) begin failures++; $display("FAIL len0_event got=%b exp=110", {bus.ev_valid, bus.ev_ch}); end
    checks++; if (bus.det !== 4'b0100) begin failures++; $display("FAIL len0_det got=%b exp=0100", bus.det); end
    tick();
    checks++; if (bus.ev_valid !== 1'b0) begin failures++; $display("FAIL len0_no_repeat got=%b exp=0", bus.ev_valid); end
    checks++; if (bus.det_cnt !== 16'd1) begin failures++; $display("FAIL len0_det_cnt got=%0d exp=1", bus.det_cnt); end
    bus.in_valid = '0;
  endtask

  task automatic test_saturate();
    int evs = 0;
    do_reset();
    bus.cfg_len  = 4'd15;
    bus.in_valid = 4'b1000;
    bus.in_bit   = 4'b1000;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (bus.ev_valid === 1'b1) evs++;
      if (k == 14) begin
        checks++; if (bus.det[3] !== 1'b0) begin failures++; $display("FAIL sat_det14 got=%b exp=0", bus.det[3]); end
      end
      if (k == 15) begin
        checks++; if ({bus.det[3], bus.ev_valid} !== 2'b11) begin failures++; $display("FAIL sat_det15 got=%b exp=11", {bus.det[3], bus.ev_valid}); end
      end
    end
    checks++; if (evs !== 1) begin failures++; $display("FAIL sat_events got=%0d exp=1", evs); end
    checks++; if (bus.det[3] !== 1'b1) begin failures++; $display("FAIL sat_det20 got=%b exp=1", bus.det[3]); end
    checks++; if (bus.det_cnt !== 16'd1) begin failures++; $display("FAIL sat_det_cnt got=%0d exp=1", bus.det_cnt); end
    bus.in_valid = '0;
  endtask

  task automatic test_cfg_change();
    do_reset();
    bus.cfg_len  = 4'd5;
    bus.in_valid = 4'b0010;
    bus.in_bit   = 4'b0010;
    tick(); tick(); tick();
    checks++; if (bus.det[1] !== 1'b0) begin failures++; $display("FAIL cfg_det_before got=%b exp=0", bus.det[1]); end
    bus.in_valid = '0;
    bus.cfg_len  = 4'd2;
    #1;
    checks++; if (bus.det[1] !== 1'b1) begin failures++; $display("FAIL cfg_det_after got=%b exp=1", bus.det[1]); end
    tick();
    checks++; if (bus.ev_valid !== 1'b0) begin failures++; $display("FAIL cfg_no_retro got=%b exp=0", bus.ev_valid); end
    bus.in_valid = 4'b0010;
    tick();
    checks++; if (bus.ev_valid !== 1'b0) begin failures++; $display("FAIL cfg_above got=%b exp=0", bus.ev_valid); end
    bus.in_bit = 4'b0000;
    tick();
    checks++; if (bus.det[1] !== 1'b0) begin failures++; $display("FAIL cfg_break got=%b exp=0", bus.det[1]); end
    bus.in_bit = 4'b0010;
    tick();
    checks++; if (bus.ev_valid !== 1'b0) begin failures++; $display("FAIL cfg_rebuild1 got=%b exp=0", bus.ev_valid); end
    tick();
    checks++; if ({bus.ev_valid, bus.ev_ch} !== 3'b101) begin failures++; $display("FAIL cfg_rebuild2 got=%b exp=101", {bus.ev_valid, bus.ev_ch}); end
    checks++; if (bus.det_cnt !== 16'd1) begin failures++; $display("FAIL cfg_det_cnt got=%0d exp=1", bus.det_cnt); end
    bus.in_valid = '0;
  endtask

  task automatic test_async_reset();
    do_reset();
    bus.cfg_len  = 4'd1;
    bus.ev_ready = 1'b0;
    bus.in_valid = 4'b0100;
    bus.in_bit   = 4'b0100;
    tick();
    checks++; if ({bus.ev_valid, bus.ev_ch, bus.det_cnt} !== {1'b1, 2'd2, 16'd1}) begin failures++; $display("FAIL arst_pending got=%b/%0d/%0d exp=1/2/1", bus.ev_valid, bus.ev_ch, bus.det_cnt); end
    bus.in_valid = 4'b1111;
    #2;
    rst = 1'b1;
    #1;
    checks++; if (bus.ev_valid !== 1'b0) begin failures++; $display("FAIL arst_ev_valid got=%b exp=0", bus.ev_valid); end
    checks++; if (bus.ev_ch !== 2'd0) begin failures++; $display("FAIL arst_ev_ch got=%0d exp=0", bus.ev_ch); end
    checks++; if (bus.det_cnt !== 16'd0) begin failures++; $display("FAIL arst_det_cnt got=%0d exp=0", bus.det_cnt); end
    checks++; if (bus.det !== 4'b0000) begin failures++; $display("FAIL arst_det got=%b exp=0000", bus.det); end
    checks++; if (bus.in_ready !== 4'b0000) begin failures++; $display("FAIL arst_in_ready got=%b exp=0000", bus.in_ready); end
    tick();
    rst          = 1'b0;
    bus.ev_ready = 1'b1;
    bus.in_bit   = 4'b0000;
    #1;
    checks++; if (bus.in_ready !== 4'b0001) begin failures++; $display("FAIL arst_first_grant got=%b exp=0001", bus.in_ready); end
    tick();
    #1;
    checks++; if (bus.in_ready !== 4'b0010) begin failures++; $display("FAIL arst_second_grant got=%b exp=0010", bus.in_ready); end
    bus.in_valid = '0;
  endtask

  initial begin
    bus.cfg_len  = 4'd3;
    bus.in_valid = '0;
    bus.in_bit   = '0;
    bus.ev_ready = 1'b1;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_back_to_back();
    test_len_zero();
    test_saturate();
    test_cfg_change();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_detect_sched.md
# seq_detect_sched

Shared run-length sequence detector for NCH serial bit channels. A round-robin scheduler grants one channel per cycle to a single detection engine. The engine keeps per-channel Moore run state and produces a level output per channel plus a one-entry event stream (channel ID) toward downstream logic. It generalises the three-1s Moore detector to a programmable run length and multiple time-shared inputs.

## Interface
- NCH, 4: number of input channels (2..8)
- CNT_W, 4: run counter width; runs saturate at 2^CNT_W-1
- CH_W, $clog2(NCH): channel ID width
- clk  in  1  rising-edge clock, single domain
- rst  in  1  reset; asynchronous, active-high
- cfg_len  in  CNT_W  required run of consecutive 1s; 0 is treated as 1 (eff_len)
- in_valid  in  NCH  per-channel bit offered
- in_bit  in  NCH  per-channel bit value
- in_ready  out  NCH  one-hot grant; a bit is consumed when in_valid[i] and in_ready[i] are both high
- det  out  NCH  Moore level: det[i] = (run[i] >= eff_len)
- ev_valid  out  1  detection event pending
- ev_ch  out  CH_W  channel of pending event
- ev_ready  in  1  downstream accepts event
- det_cnt  out  16  total events issued, wraps at 2^16

## Operation
- slot_free = !ev_valid | ev_ready. When slot_free is low, in_ready = 0 (full stall) and no run state changes.
- Arbiter is round-robin over in_valid. The search starts at ptr and wraps. in_ready is combinational, at most one bit set, and only when slot_free.
- ptr updates to (granted+1) mod NCH on each grant. Otherwise it holds.
- On accept from channel g:
  - bit=1: run[g] <= min(run[g]+1, 2^CNT_W-1).
  - bit=0: run[g] <= 0.
- Event is raised when an accept has bit=1 and run[g]+1 == eff_len. This is the rising edge of the detection only: continued 1s keep det high but raise no new event.
- On event:
  - ev_valid <= 1, ev_ch <= g, det_cnt <= det_cnt+1.
  - Otherwise, if ev_ready, ev_valid <= 0.
- Simultaneous ev_ready pop and new event: the new event is loaded and ev_valid stays 1.
- Non-granted channels hold their run state.
- cfg_len change mid-run: det is re-evaluated against the new eff_len immediately. No event is raised retroactively. A run already above the new eff_len raises no event until it is broken by a 0 and rebuilt.
- Reset mid-operation: all state clears; any pending event is lost.
- Reset values:
  - run[*] = 0, so det = 0.
  - ev_valid = 0, ev_ch = 0, det_cnt = 0, ptr = 0 (channel 0 first).
  - in_ready = 0 while rst is asserted.

## Timing
- Accept on edge N: run and det update at edge N; visible after N.
- Event: ev_valid high in the cycle after the accepting edge (latency 1).
- Throughput: 1 accepted bit per cycle aggregate while downstream keeps ev_ready high.
- Stall: ev_valid=1 with ev_ready=0 blocks all channels until the event pops. The event is not dropped and is not overwritten.
- det is registered-state derived. It changes only on accepts and on cfg_len changes (combinational compare).

## Structure
- Package seq_detect_pkg: NCH/CNT_W defaults, CH_W, DET_CNT_W=16, eff_len helper function.
- Sub-module rr_arb (NCH-wide round-robin arbiter):
  - Inputs: req, en, ptr.
  - Outputs: one-hot gnt and binary gnt_id.
  - Reused elsewhere.
- Top level contains: the run-counter array, the event register, det compare, det_cnt.

## Test plan
- Single channel, cfg_len=3, stream 1,1,1,1,0 on ch0:
  - det[0] rises after the 3rd accept.
  - Exactly one event, ev_ch=0, det_cnt=1.
  - det[0] falls after the 0.
- Round-robin: all 4 in_valid held high from reset.
  - Grants are ch0,1,2,3,0,…, one per cycle.
  - No channel is starved over 16 cycles.
- Back-pressure: ev_ready=0 while an event pends.
  - in_ready=0 on all channels and run state is frozen.
  - Raising ev_ready pops the event and grants resume the same cycle.
- Simultaneous pop and new event, ev_ready=1:
  - Two channels complete runs in consecutive cycles (cfg_len=2).
  - ev_valid stays high and ev_ch goes 0 then 1.
  - det_cnt=2.
- Boundaries:
  - cfg_len=0 behaves as 1: the first 1 yields an event.
  - CNT_W=4 with 20 consecutive 1s: run saturates at 15, no wrap, no extra event.
  - cfg_len lowered from 5 to 2 at run=3: det goes high, no event.
- Asynchronous rst pulse mid-stream with an event pending:
  - All outputs return to their reset values without waiting for a clock edge.
  - After reset, ch0 is granted first.
